// File: rtl/cam_fill_ctrl.sv
// Lookup/fill/flush sequencer between a single requester and a tag-matching CAM.
// Latency: hit responds two edges after the request handshake; miss responds two edges after mem_ack.
// Backpressure: req_ready drops outside IDLE; the response is held until rsp_ready.
module cam_fill_ctrl #(
  parameter int WORDS  = 8,
  parameter int BITS   = 8,
  parameter int TAG_SZ = 8,
  localparam int ADDR_LEFT = $clog2(WORDS) - 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic [TAG_SZ-1:0]    req_tag,
  output logic                 req_ready,
  input  logic                 flush_req,
  output logic                 flush_done,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BITS-1:0]      rsp_data,
  output logic                 rsp_hit,
  output logic                 mem_req,
  output logic [TAG_SZ-1:0]    mem_tag,
  input  logic                 mem_ack,
  input  logic [BITS-1:0]      mem_rdata,
  output logic [TAG_SZ-1:0]    cam_check_tag,
  output logic                 cam_read,
  input  logic                 cam_found,
  input  logic [BITS-1:0]      cam_data,
  output logic                 cam_write_,
  output logic [ADDR_LEFT:0]   cam_w_addr,
  output logic [BITS-1:0]      cam_wdata,
  output logic [TAG_SZ-1:0]    cam_new_tag,
  output logic                 cam_new_valid
);

  localparam int AW = ADDR_LEFT + 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    MISS_REQ = 3'd2,
    FILL     = 3'd3,
    RESP     = 3'd4,
    FLUSH    = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [TAG_SZ-1:0] tag_q;
  logic [BITS-1:0]   line_q;
  logic [BITS-1:0]   rsp_data_q;
  logic              rsp_hit_q;
  logic [WORDS-1:0]  shadow;
  logic [AW-1:0]     rr;
  logic [AW-1:0]     idx;
  logic [AW-1:0]     victim;
  logic              have_free;
  logic              req_fire;

  assign req_fire = req_valid & req_ready;
  assign rsp_data = rsp_data_q;
  assign rsp_hit  = rsp_hit_q;

  // Victim: lowest entry the shadow marks empty, else the round-robin pointer.
  always_comb begin
    victim    = rr;
    have_free = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      if (!have_free && !shadow[i]) begin
        victim    = i[AW-1:0];
        have_free = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and all strobes; outputs are pure state decodes so reset drops them at once.
  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    flush_done    = 1'b0;
    rsp_valid     = 1'b0;
    mem_req       = 1'b0;
    mem_tag       = '0;
    cam_check_tag = '0;
    cam_read      = 1'b0;
    cam_write_    = 1'b1;
    cam_w_addr    = '0;
    cam_wdata     = '0;
    cam_new_tag   = '0;
    cam_new_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = ~flush_req;
        if (flush_req) begin
          state_nxt = FLUSH;
        end else if (req_valid) begin
          state_nxt = LOOKUP;
        end
      end
      LOOKUP: begin
        cam_check_tag = tag_q;
        cam_read      = 1'b1;
        state_nxt     = cam_found ? RESP : MISS_REQ;
      end
      MISS_REQ: begin
        mem_req = 1'b1;
        mem_tag = tag_q;
        if (mem_ack) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        cam_write_    = 1'b0;
        cam_w_addr    = victim;
        cam_wdata     = line_q;
        cam_new_tag   = tag_q;
        cam_new_valid = 1'b1;
        state_nxt     = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      FLUSH: begin
        cam_write_ = 1'b0;
        cam_w_addr = idx;
        if (idx == LAST_IDX) begin
          flush_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request tag capture on the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q <= '0;
    end else if (req_fire) begin
      tag_q <= req_tag;
    end
  end

  // Fetched line is latched only while actually waiting for memory; stray acks are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
    end else if (state == MISS_REQ && mem_ack) begin
      line_q <= mem_rdata;
    end
  end

  // Response registers load on a CAM hit or at the end of a fill and hold through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_data_q <= '0;
      rsp_hit_q  <= 1'b0;
    end else if (state == LOOKUP && cam_found) begin
      rsp_data_q <= cam_data;
      rsp_hit_q  <= 1'b1;
    end else if (state == FILL) begin
      rsp_data_q <= line_q;
      rsp_hit_q  <= 1'b0;
    end
  end

  // Shadow valid tracking, round-robin pointer and flush walk index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      rr     <= '0;
      idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_req) begin
            idx <= '0;
          end
        end
        FILL: begin
          shadow[victim] <= 1'b1;
          // The pointer only moves when a valid entry had to be evicted.
          if (!have_free) begin
            rr <= (rr == LAST_IDX) ? '0 : rr + AW'(1);
          end
        end
        FLUSH: begin
          shadow[idx] <= 1'b0;
          if (idx == LAST_IDX) begin
            idx <= '0;
            rr  <= '0;
          end else begin
            idx <= idx + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_fill_ctrl.sv
// Self-checking bench for cam_fill_ctrl: directed scenarios followed by random lookups/flushes.
// Expected results come from a cache-content model (resident tags, empty slots, eviction pointer).
// A small CAM array stands in for the real CAM and is written only through the DUT write port.
module tb_cam_fill_ctrl;
  localparam int WORDS = 8;
  localparam int BITS  = 8;
  localparam int TSZ   = 8;
  localparam int AW    = 3;

  logic            clk, rst;
  logic            req_valid, req_ready, flush_req, flush_done;
  logic [TSZ-1:0]  req_tag;
  logic            rsp_valid, rsp_ready, rsp_hit;
  logic [BITS-1:0] rsp_data;
  logic            mem_req, mem_ack;
  logic [TSZ-1:0]  mem_tag;
  logic [BITS-1:0] mem_rdata;
  logic [TSZ-1:0]  cam_check_tag;
  logic            cam_read, cam_found;
  logic [BITS-1:0] cam_data;
  logic            cam_write_;
  logic [AW-1:0]   cam_w_addr;
  logic [BITS-1:0] cam_wdata;
  logic [TSZ-1:0]  cam_new_tag;
  logic            cam_new_valid;

  int tests = 0;
  int fails = 0;

  cam_fill_ctrl #(.WORDS(WORDS), .BITS(BITS), .TAG_SZ(TSZ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_tag(req_tag), .req_ready(req_ready),
    .flush_req(flush_req), .flush_done(flush_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
    .mem_req(mem_req), .mem_tag(mem_tag), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .cam_check_tag(cam_check_tag), .cam_read(cam_read), .cam_found(cam_found), .cam_data(cam_data),
    .cam_write_(cam_write_), .cam_w_addr(cam_w_addr), .cam_wdata(cam_wdata),
    .cam_new_tag(cam_new_tag), .cam_new_valid(cam_new_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in CAM: combinational match, write on the clock edge while the strobe is low.
  logic [TSZ-1:0]  env_tag [WORDS];
  logic [BITS-1:0] env_dat [WORDS];
  logic            env_v   [WORDS];

  always_comb begin
    cam_found = 1'b0;
    cam_data  = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (env_v[i] && env_tag[i] == cam_check_tag) begin
        cam_found = 1'b1;
        cam_data  = env_dat[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WORDS; i++) begin
        env_v[i]   <= 1'b0;
        env_tag[i] <= '0;
        env_dat[i] <= '0;
      end
    end else if (!cam_write_) begin
      env_v[cam_w_addr]   <= cam_new_valid;
      env_tag[cam_w_addr] <= cam_new_tag;
      env_dat[cam_w_addr] <= cam_wdata;
    end
  end

  // Reference cache contents.
  logic [TSZ-1:0]  m_tag [WORDS];
  logic [BITS-1:0] m_dat [WORDS];
  bit              m_v   [WORDS];
  int              m_rr;

  function automatic void model_clear();
    for (int i = 0; i < WORDS; i++) m_v[i] = 1'b0;
    m_rr = 0;
  endfunction

  function automatic int model_find(input logic [TSZ-1:0] t);
    for (int i = 0; i < WORDS; i++) if (m_v[i] && m_tag[i] == t) return i;
    return -1;
  endfunction

  function automatic int model_empty_slot();
    for (int i = 0; i < WORDS; i++) if (!m_v[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One lookup from IDLE through response release; fixed_d < 0 means random fill data.
  task automatic lookup(input logic [TSZ-1:0] t, input int hold, input int fixed_d);
    int hi, vic, slot, waits;
    logic [BITS-1:0] d;
    chk("idle_ready", req_ready, 1);
    req_valid = 1'b1;
    req_tag   = t;
    tick();
    // Stray request and stray ack while busy must both be ignored.
    req_tag   = t ^ 8'hFF;
    mem_ack   = 1'b1;
    mem_rdata = BITS'($urandom);
    #1;
    chk("lk_read", cam_read, 1);
    chk("lk_tag", cam_check_tag, t);
    chk("lk_ready", req_ready, 0);
    chk("lk_novld", rsp_valid, 0);
    hi = model_find(t);
    tick();
    mem_ack = 1'b0;
    if (hi >= 0) begin
      d = m_dat[hi];
      chk("hit_vld", rsp_valid, 1);
      chk("hit_data", rsp_data, d);
      chk("hit_flag", rsp_hit, 1);
      chk("hit_nomem", mem_req, 0);
    end else begin
      chk("mreq", mem_req, 1);
      chk("mtag", mem_tag, t);
      chk("miss_nowr", cam_write_, 1);
      waits = $urandom_range(0, 3);
      repeat (waits) begin
        tick();
        chk("mreq_hold", mem_req, 1);
        chk("mtag_hold", mem_tag, t);
      end
      d = (fixed_d >= 0) ? BITS'(fixed_d) : BITS'($urandom);
      mem_ack   = 1'b1;
      mem_rdata = d;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = BITS'($urandom);
      slot = model_empty_slot();
      vic  = (slot >= 0) ? slot : m_rr;
      chk("fill_we", cam_write_, 0);
      chk("fill_addr", cam_w_addr, vic);
      chk("fill_wdata", cam_wdata, d);
      chk("fill_tag", cam_new_tag, t);
      chk("fill_nv", cam_new_valid, 1);
      chk("fill_mreq", mem_req, 0);
      chk("fill_novld", rsp_valid, 0);
      if (slot < 0) m_rr = (m_rr + 1) % WORDS;
      m_v[vic]   = 1'b1;
      m_tag[vic] = t;
      m_dat[vic] = d;
      tick();
      chk("miss_vld", rsp_valid, 1);
      chk("miss_data", rsp_data, d);
      chk("miss_flag", rsp_hit, 0);
      chk("miss_we", cam_write_, 1);
    end
    rsp_ready = 1'b0;
    repeat (hold) begin
      tick();
      chk("hold_vld", rsp_valid, 1);
      chk("hold_data", rsp_data, d);
      chk("hold_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rel_ready", req_ready, 1);
    chk("rel_novld", rsp_valid, 0);
  endtask

  // Full flush walk from IDLE, optionally with a competing request.
  task automatic flush(input bit with_req);
    flush_req = 1'b1;
    req_valid = with_req;
    req_tag   = 8'h55;
    #1;
    chk("fl_req_block", req_ready, 0);
    tick();
    flush_req = 1'b0;
    req_valid = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      chk("fl_we", cam_write_, 0);
      chk("fl_addr", cam_w_addr, i);
      chk("fl_nv", cam_new_valid, 0);
      chk("fl_wdata", cam_wdata, 0);
      chk("fl_tag", cam_new_tag, 0);
      chk("fl_done", flush_done, (i == WORDS - 1) ? 1 : 0);
      chk("fl_noread", cam_read, 0);
      tick();
    end
    chk("fl_end_ready", req_ready, 1);
    chk("fl_end_done", flush_done, 0);
    chk("fl_end_we", cam_write_, 1);
    model_clear();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_vld"}, rsp_valid, 0);
    chk({tag, "_mreq"}, mem_req, 0);
    chk({tag, "_we"}, cam_write_, 1);
    chk({tag, "_read"}, cam_read, 0);
    chk({tag, "_done"}, flush_done, 0);
    chk({tag, "_data"}, rsp_data, 0);
    chk({tag, "_hit"}, rsp_hit, 0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_tag = '0; flush_req = 1'b0;
    rsp_ready = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    chk("rst_mtag", mem_tag, 0);
    chk("rst_ctag", cam_check_tag, 0);
    chk("rst_waddr", cam_w_addr, 0);
    chk("rst_wdata", cam_wdata, 0);
    chk("rst_ntag", cam_new_tag, 0);
    chk("rst_nv", cam_new_valid, 0);
    rst = 1'b0;
    tick();

    // First miss goes to entry 0 with the given line, then repeated hits.
    lookup(8'h11, 0, 8'hA5);
    chk("t1_slot0", m_v[0] && m_tag[0] == 8'h11, 1);
    lookup(8'h11, 0, -1);
    lookup(8'h11, 5, -1);
    lookup(8'h12, 5, -1);

    // Flush wins over a simultaneous request; afterwards 0x20 misses.
    flush(1'b1);
    lookup(8'h20, 0, -1);
    for (int k = 1; k < 8; k++) lookup(TSZ'(8'h20 + k), 0, -1);
    // Full cache: round-robin evicts 0, then 1, ... and wraps back to 0.
    for (int k = 0; k < 9; k++) lookup(TSZ'(8'h30 + k), 0, -1);
    lookup(8'h27, 0, -1);
    lookup(8'h38, 1, -1);

    // Reset while waiting for memory.
    req_valid = 1'b1; req_tag = 8'h77;
    tick();
    req_valid = 1'b0;
    tick();
    chk("r6_mreq_before", mem_req, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("r6");
    mem_ack = 1'b1; mem_rdata = 8'h3C;
    tick();
    chk("r6_nowrite", cam_write_, 1);
    mem_ack = 1'b0;
    rst = 1'b0;
    model_clear();
    tick();
    chk("r6_idle", req_ready, 1);
    chk("r6_mreq_after", mem_req, 0);

    // Reset part-way through a flush walk.
    lookup(8'h61, 0, -1);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
    tick();
    chk("rf_walking", cam_w_addr, 2);
    rst = 1'b1;
    #1;
    check_reset_outputs("rf");
    tick();
    rst = 1'b0;
    model_clear();
    tick();
    lookup(8'h61, 0, -1);
    chk("rf_refill_slot", m_tag[0], 8'h61);

    // Random traffic over a tag pool larger than the cache.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 11) == 0) begin
        flush(1'($urandom_range(0, 1)));
      end else begin
        lookup(TSZ'($urandom_range(8'h40, 8'h4B)), $urandom_range(0, 2), -1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net so the bench always ends on its own.
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
